// File: rtl/mmio_bus_fabric_if.sv
// Master-side MMIO request/response bus between a processor core and mmio_bus_fabric.
// The core uses the master modport; the fabric uses the slave modport.
interface mmio_bus_fabric_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_err;

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata, m_err
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata, m_err
  );
endinterface

// File: rtl/mmio_bus_fabric.sv
// Single-master MMIO fabric: address decode, one-hot slave select, ack timeout and error response.
// Optional host mailbox write bypass is enabled with `define MMIO_TOHOST_EN.
module mmio_bus_fabric #(
  parameter int NUM_SLAVES = 4,
  // Slave 0 is the catch-all, slave 1 at 0xFFFF0000, slave 2 at 0xFFFF0010, slave 3 at address 0 only.
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h0000_0000, 32'hFFFF_0010, 32'hFFFF_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_0000},
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000
) (
  input  logic                       clk,
  input  logic                       rst,
  mmio_bus_fabric_if.slave           m,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic                       s_we,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES-1:0]      s_ack,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  output logic                       host_write_enable,
  output logic [31:0]                host_data_out
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_hit;
  logic [7:0]       cnt;
  logic             ready_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic             tohost_hit;
  logic [31:0]      slv_rdata [NUM_SLAVES];

  assign m.m_ready = ready_q;
  assign m.m_err   = err_q;
  assign m.m_rdata = rdata_q;

  always_comb begin
    for (int k = 0; k < NUM_SLAVES; k++) begin
      slv_rdata[k] = s_rdata[32*k +: 32];
    end
  end

  // Later matches overwrite earlier ones, so the highest matching index wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if ((m.m_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(k);
      end
    end
  end

`ifdef MMIO_TOHOST_EN
  assign tohost_hit = m.m_we && (m.m_addr == TOHOST_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      host_write_enable <= 1'b0;
      host_data_out     <= '0;
    end else begin
      host_write_enable <= (state == IDLE) && m.m_req && tohost_hit;
      if ((state == IDLE) && m.m_req && tohost_hit) begin
        host_data_out <= m.m_wdata;
      end
    end
  end
`else
  logic unused_tohost;

  assign tohost_hit        = 1'b0;
  assign unused_tohost     = ^TOHOST_ADDR;
  assign host_write_enable = 1'b0;
  assign host_data_out     = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      s_sel   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
      idx_q   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
    end else begin
      // Response outputs are pulses; only the RESP-entering branches raise them.
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state)
        IDLE: begin
          if (m.m_req) begin
            if (tohost_hit) begin
              state   <= RESP;
              ready_q <= 1'b1;
            end else if (dec_hit) begin
              state   <= ACCESS;
              idx_q   <= dec_idx;
              s_sel   <= NUM_SLAVES'(1) << dec_idx;
              cnt     <= 8'd1;
              s_we    <= m.m_we;
              s_addr  <= m.m_addr;
              s_wdata <= m.m_wdata;
              s_wstrb <= m.m_wstrb;
            end else begin
              state   <= RESP;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // An ack in the final counted cycle still beats the timeout.
          if (s_ack[idx_q]) begin
            state   <= RESP;
            s_sel   <= '0;
            ready_q <= 1'b1;
            rdata_q <= s_we ? 32'h0 : slv_rdata[idx_q];
          end else if (cnt == 8'(TIMEOUT_CYCLES)) begin
            state   <= RESP;
            s_sel   <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          s_sel <= '0;
        end
      endcase
    end
  end

endmodule
